dmem_access_arbiter: RTL and testbench

//  Two-port arbiter/sequencer for the 512-byte byte-addressed data memory.

---
 rtl/dmem_access_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_access_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_arbiter.sv
// rtl/dmem_access_arbiter.sv - two-port arbiter/sequencer for the 512-byte data memory
module dmem_access_arbiter #(
    parameter int ADDR_W     = 9,
    parameter int ACCESS_CYC = 1,
    parameter int FAIR       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_rw,
    input  logic              req0_sext,
    input  logic [1:0]        req0_size,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_rw,
    input  logic              req1_sext,
    input  logic [1:0]        req1_size,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              resp0_valid,
    output logic [31:0]       resp0_rdata,
    output logic              resp0_err,
    output logic              resp1_valid,
    output logic [31:0]       resp1_rdata,
    output logic              resp1_err,
    output logic              mem_enable,
    output logic              mem_rw,
    output logic              mem_sext,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);
    localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERR} state_t;

    state_t            state;
    logic              prio;
    logic              owner;
    logic [CNT_W-1:0]  cnt;
    logic              grant0, grant1, accept;
    logic              sel_rw, sel_sext, sel_err;
    logic [1:0]        sel_size;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;

    // prio names the port that wins a tie next time (only used when FAIR)
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if ((FAIR != 0) && prio)
                grant1 = 1'b1;
            else
                grant0 = 1'b1;
        end else if (req0_valid) begin
            grant0 = 1'b1;
        end else if (req1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && (grant0 || grant1);
    assign req0_ready = (state == IDLE) && grant0 && !reset;
    assign req1_ready = (state == IDLE) && grant1 && !reset;
    assign busy       = (state != IDLE);

    assign sel_rw    = grant1 ? req1_rw    : req0_rw;
    assign sel_sext  = grant1 ? req1_sext  : req0_sext;
    assign sel_size  = grant1 ? req1_size  : req0_size;
    assign sel_addr  = grant1 ? req1_addr  : req0_addr;
    assign sel_wdata = grant1 ? req1_wdata : req0_wdata;
    assign sel_err   = (sel_size == 2'b11) ||
                       ((sel_size == 2'b01) && sel_addr[0]) ||
                       ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prio        <= 1'b0;
            owner       <= 1'b0;
            cnt         <= '0;
            mem_enable  <= 1'b0;
            mem_rw      <= 1'b0;
            mem_sext    <= 1'b0;
            mem_size    <= 2'b00;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            resp0_valid <= 1'b0;
            resp0_err   <= 1'b0;
            resp0_rdata <= '0;
            resp1_valid <= 1'b0;
            resp1_err   <= 1'b0;
            resp1_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner <= grant1;
                        prio  <= grant0;
                        if (sel_err) begin
                            state       <= ERR;
                            resp0_valid <= grant0;
                            resp0_err   <= grant0;
                            resp1_valid <= grant1;
                            resp1_err   <= grant1;
                        end else begin
                            state     <= SETUP;
                            mem_rw    <= sel_rw;
                            mem_sext  <= sel_sext;
                            mem_size  <= sel_size;
                            mem_addr  <= sel_addr;
                            mem_wdata <= sel_wdata;
                        end
                    end
                end
                SETUP: begin
                    state      <= ACCESS;
                    mem_enable <= 1'b1;
                    cnt        <= '0;
                end
                ACCESS: begin
                    if (cnt == LAST_CNT) begin
                        // DataOut is captured on the edge that closes the final enable cycle
                        state      <= DONE;
                        mem_enable <= 1'b0;
                        if (owner) begin
                            resp1_valid <= 1'b1;
                            resp1_rdata <= mem_rw ? 32'h0 : mem_rdata;
                        end else begin
                            resp0_valid <= 1'b1;
                            resp0_rdata <= mem_rw ? 32'h0 : mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE, ERR: begin
                    state       <= IDLE;
                    resp0_valid <= 1'b0;
                    resp0_err   <= 1'b0;
                    resp0_rdata <= '0;
                    resp1_valid <= 1'b0;
                    resp1_err   <= 1'b0;
                    resp1_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_access_arbiter.sv
// tb/tb_dmem_access_arbiter.sv - randomized bench for dmem_access_arbiter against a byte-array model
module tb_dmem_access_arbiter;
    localparam int AC = 3;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;
    always #5 clk = ~clk;

    logic        req0_valid, req0_ready, req0_rw, req0_sext;
    logic [1:0]  req0_size;
    logic [8:0]  req0_addr;
    logic [31:0] req0_wdata;
    logic        req1_valid, req1_ready, req1_rw, req1_sext;
    logic [1:0]  req1_size;
    logic [8:0]  req1_addr;
    logic [31:0] req1_wdata;
    logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
    logic [31:0] resp0_rdata, resp1_rdata;
    logic        mem_enable, mem_rw, mem_sext, busy;
    logic [1:0]  mem_size;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    dmem_access_arbiter #(.ADDR_W(9), .ACCESS_CYC(AC), .FAIR(1)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rw(req0_rw),
        .req0_sext(req0_sext), .req0_size(req0_size), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rw(req1_rw),
        .req1_sext(req1_sext), .req1_size(req1_size), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
        .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_sext(mem_sext),
        .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Second instance: strict priority, single-cycle access, memory data unused
    logic        b0_valid, b0_ready, b1_valid, b1_ready;
    logic        b_resp0_valid, b_resp0_err, b_resp1_valid, b_resp1_err;
    logic [31:0] b_resp0_rdata, b_resp1_rdata;
    logic        b_mem_enable, b_mem_rw, b_mem_sext, b_busy;
    logic [1:0]  b_mem_size;
    logic [8:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [31:0] b_mem_rdata = 32'h0;

    dmem_access_arbiter #(.ADDR_W(9), .ACCESS_CYC(1), .FAIR(0)) dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(b0_valid), .req0_ready(b0_ready), .req0_rw(1'b0),
        .req0_sext(1'b0), .req0_size(2'b10), .req0_addr(9'h000),
        .req0_wdata(32'h0),
        .req1_valid(b1_valid), .req1_ready(b1_ready), .req1_rw(1'b0),
        .req1_sext(1'b0), .req1_size(2'b10), .req1_addr(9'h004),
        .req1_wdata(32'h0),
        .resp0_valid(b_resp0_valid), .resp0_rdata(b_resp0_rdata), .resp0_err(b_resp0_err),
        .resp1_valid(b_resp1_valid), .resp1_rdata(b_resp1_rdata), .resp1_err(b_resp1_err),
        .mem_enable(b_mem_enable), .mem_rw(b_mem_rw), .mem_sext(b_mem_sext),
        .mem_size(b_mem_size), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int vectors = 0;
    int miscompares = 0;
    int en_cnt = 0;
    int last_grant = 1;
    logic [7:0] ref_mem [512];
    logic [7:0] env_mem [512];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Big-endian formatting of up to four bytes starting at the addressed byte
    function automatic logic [31:0] fmt(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3,
                                        input logic [1:0] sz, input logic sx);
        case (sz)
            2'b00:   return sx ? {{24{b0[7]}}, b0} : {24'h0, b0};
            2'b01:   return sx ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
            default: return {b0, b1, b2, b3};
        endcase
    endfunction

    assign mem_rdata = fmt(env_mem[mem_addr], env_mem[mem_addr + 9'd1],
                           env_mem[mem_addr + 9'd2], env_mem[mem_addr + 9'd3],
                           mem_size, mem_sext);

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 512; i++) env_mem[i] <= 8'(i * 7 + 3);
        end else if (mem_enable && mem_rw) begin
            case (mem_size)
                2'b00: env_mem[mem_addr] <= mem_wdata[7:0];
                2'b01: begin
                    env_mem[mem_addr]        <= mem_wdata[15:8];
                    env_mem[mem_addr + 9'd1] <= mem_wdata[7:0];
                end
                default: begin
                    env_mem[mem_addr]        <= mem_wdata[31:24];
                    env_mem[mem_addr + 9'd1] <= mem_wdata[23:16];
                    env_mem[mem_addr + 9'd2] <= mem_wdata[15:8];
                    env_mem[mem_addr + 9'd3] <= mem_wdata[7:0];
                end
            endcase
        end
    end

    always @(negedge clk) if (mem_enable) en_cnt++;

    task automatic drive(input int p, input logic v, input logic rw, input logic sx,
                         input logic [1:0] sz, input logic [8:0] a, input logic [31:0] wd);
        if (p == 0) begin
            req0_valid = v; req0_rw = rw; req0_sext = sx; req0_size = sz;
            req0_addr = a; req0_wdata = wd;
        end else begin
            req1_valid = v; req1_rw = rw; req1_sext = sx; req1_size = sz;
            req1_addr = a; req1_wdata = wd;
        end
    endtask

    // One full request: issue, wait for acceptance, then check the response against the model
    task automatic xfer(input int p, input logic rw, input logic sx, input logic [1:0] sz,
                        input logic [8:0] a, input logic [31:0] wd);
        int n;
        logic e;
        logic [31:0] exp;
        e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
        exp = (e || rw) ? 32'h0 :
              fmt(ref_mem[a], ref_mem[a + 9'd1], ref_mem[a + 9'd2], ref_mem[a + 9'd3], sz, sx);
        drive(p, 1'b1, rw, sx, sz, a, wd);
        n = 0;
        #1;
        while (!(p == 1 ? req1_ready : req0_ready) && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            chk("ready_timeout", 32'(n), 32'd0);
            drive(p, 1'b0, rw, sx, sz, a, wd);
            return;
        end
        @(posedge clk);
        en_cnt = 0;
        last_grant = p;
        @(negedge clk); #1;
        drive(p, 1'b0, rw, sx, sz, a, wd);
        n = 1;
        while (!(p == 1 ? resp1_valid : resp0_valid) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        chk("latency", 32'(n), e ? 32'd1 : 32'(AC + 2));
        chk("resp_err", {31'h0, p == 1 ? resp1_err : resp0_err}, {31'h0, e});
        chk("resp_rdata", p == 1 ? resp1_rdata : resp0_rdata, exp);
        chk("other_resp", {31'h0, p == 1 ? resp0_valid : resp1_valid}, 32'h0);
        chk("busy_resp", {31'h0, busy}, 32'h1);
        chk("en_cycles", 32'(en_cnt), e ? 32'd0 : 32'(AC));
        if (!e && rw) begin
            case (sz)
                2'b00: ref_mem[a] = wd[7:0];
                2'b01: begin ref_mem[a] = wd[15:8]; ref_mem[a + 9'd1] = wd[7:0]; end
                default: begin
                    ref_mem[a] = wd[31:24]; ref_mem[a + 9'd1] = wd[23:16];
                    ref_mem[a + 9'd2] = wd[15:8]; ref_mem[a + 9'd3] = wd[7:0];
                end
            endcase
        end
        @(negedge clk); #1;
        chk("busy_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, g, g0, g1, r1;
        int exp_port;
        logic [1:0] sz;
        logic [8:0] a;

        reset = 1'b1;
        mem_clear = 1'b1;
        b0_valid = 1'b0;
        b1_valid = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 2'b10, 9'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 2'b10, 9'h4, 32'h0);
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'(i * 7 + 3);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready0", {31'h0, req0_ready}, 32'h0);
        chk("rst_ready1", {31'h0, req1_ready}, 32'h0);
        chk("rst_enable", {31'h0, mem_enable}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_addr", {23'h0, mem_addr}, 32'h0);
        chk("rst_resp", {30'h0, resp1_valid, resp0_valid}, 32'h0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_clear = 1'b0;
        @(negedge clk);

        xfer(0, 1'b1, 1'b0, 2'b10, 9'h010, 32'hDEADBEEF);
        xfer(0, 1'b0, 1'b0, 2'b10, 9'h010, 32'h0);
        xfer(1, 1'b1, 1'b0, 2'b00, 9'h003, 32'h00000080);
        xfer(1, 1'b0, 1'b1, 2'b00, 9'h003, 32'h0);
        xfer(1, 1'b0, 1'b0, 2'b00, 9'h003, 32'h0);
        xfer(0, 1'b0, 1'b0, 2'b01, 9'h005, 32'h0);
        xfer(1, 1'b1, 1'b0, 2'b10, 9'h002, 32'h12345678);
        xfer(0, 1'b0, 1'b0, 2'b11, 9'h000, 32'h0);
        xfer(0, 1'b0, 1'b0, 2'b10, 9'h1FC, 32'h0);
        xfer(1, 1'b0, 1'b0, 2'b10, 9'h000, 32'h0);

        // Both ports continuously valid: grants must alternate
        drive(0, 1'b1, 1'b0, 1'b0, 2'b10, 9'h020, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 2'b10, 9'h040, 32'h0);
        exp_port = 1 - last_grant;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < 50) begin
                @(negedge clk); #1; n++;
            end
            g = req1_ready ? 1 : 0;
            chk("arb_both", {30'h0, req1_ready, req0_ready}, g == 1 ? 32'h2 : 32'h1);
            chk("arb_port", 32'(g), 32'(exp_port));
            @(posedge clk);
            last_grant = g;
            exp_port = 1 - g;
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (AC + 4) @(negedge clk);

        // Reset in the middle of an access
        drive(0, 1'b1, 1'b0, 1'b0, 2'b10, 9'h010, 32'h0);
        n = 0;
        #1;
        while (!req0_ready && n < 50) begin @(negedge clk); #1; n++; end
        @(posedge clk);
        @(negedge clk); #1;
        n = 0;
        while (!mem_enable && n < 10) begin @(negedge clk); #1; n++; end
        chk("rst_reached_access", {31'h0, mem_enable}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_mid_enable", {31'h0, mem_enable}, 32'h0);
        chk("rst_mid_busy", {31'h0, busy}, 32'h0);
        chk("rst_mid_ready", {31'h0, req0_ready}, 32'h0);
        req0_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        last_grant = 1;
        r1 = 0;
        for (int k = 0; k < AC + 4; k++) begin
            @(negedge clk); #1;
            if (resp0_valid || resp1_valid || mem_enable) r1++;
        end
        chk("rst_no_resp", 32'(r1), 32'h0);
        xfer(0, 1'b0, 1'b0, 2'b10, 9'h010, 32'h0);

        // Strict-priority instance: port 1 must starve
        b0_valid = 1'b1;
        b1_valid = 1'b1;
        g0 = 0; g1 = 0; r1 = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (b0_ready) g0++;
            if (b1_ready) g1++;
            if (b_resp1_valid) r1++;
            @(negedge clk);
        end
        b0_valid = 1'b0;
        b1_valid = 1'b0;
        chk("fair0_port0_grants", 32'(g0), 32'd10);
        chk("fair0_port1_grants", 32'(g1), 32'd0);
        chk("fair0_port1_resp", 32'(r1), 32'd0);

        for (int k = 0; k < 40; k++) begin
            sz = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 1) == 1) ? 9'($urandom_range(0, 31)) : 9'($urandom_range(0, 511));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 sz, a, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
